// File: rtl/riscv_muldiv_pkg.sv
// Shared encodings for the M-extension request scheduler.
package riscv_muldiv_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned TAG_W_DEF = 4;

  // Scheduler state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  // M-extension funct3 encodings
  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  // Operation presented to the mul/div unit
  typedef struct packed {
    logic [2:0]      funct3;
    logic [XLEN-1:0] s1;
    logic [XLEN-1:0] s2;
  } mul_op_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; pointer remembers the last granted requester.
module rr_arbiter2 (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] grant_c
);

  // 1 means requester 1 was granted last, so requester 0 wins the next tie
  logic last_q;

  // Grant the single requester, or on a tie the one not granted last
  always_comb begin
    grant_c = 2'b00;
    if (en) begin
      if (req == 2'b11) grant_c = last_q ? 2'b01 : 2'b10;
      else              grant_c = req;
    end
  end

  // Advance the pointer whenever a grant is issued
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)      last_q <= 1'b1;
    else if (|grant_c) last_q <= grant_c[1];
  end

endmodule

// File: rtl/mul_div_scheduler.sv
// Shares one multi-cycle mul/div unit between two requesters, with kill support.
module mul_div_scheduler
  import riscv_muldiv_pkg::*;
#(
  parameter int unsigned TAG_W = TAG_W_DEF
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [5:0]         req_funct3,
  input  logic [63:0]        req_s1,
  input  logic [63:0]        req_s2,
  input  logic [2*TAG_W-1:0] req_tag,
  input  logic [1:0]         kill,
  output logic [1:0]         rsp_valid,
  input  logic [1:0]         rsp_ready,
  output logic [31:0]        rsp_data,
  output logic [TAG_W-1:0]   rsp_tag,
  output logic               mul_enabled,
  output logic [2:0]         mul_funct3,
  output logic [31:0]        mul_s1,
  output logic [31:0]        mul_s2,
  input  logic [31:0]        mul_rd,
  input  logic               mul_wait,
  output logic               busy
);

  logic [1:0]       state_q, state_d;
  mul_op_t          op_q;
  logic [TAG_W-1:0] tag_q;
  logic             owner_q;
  logic [XLEN-1:0]  result_q;

  logic       arb_en_c;
  logic [1:0] grant_c;
  logic       accept_c;
  logic       gidx_c;
  logic       kill_own_c;

  // Arbitration only while idle; gated by reset so req_ready stays low in reset
  assign arb_en_c   = (state_q == ST_IDLE) && reset_n;
  assign accept_c   = |grant_c;
  assign gidx_c     = grant_c[1];
  assign kill_own_c = kill[owner_q];

  rr_arbiter2 u_arb (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (arb_en_c),
    .req     (req_valid),
    .grant_c (grant_c)
  );

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next state and state-decoded outputs
  always_comb begin
    state_d     = state_q;
    req_ready   = 2'b00;
    mul_enabled = 1'b0;
    mul_funct3  = 3'd0;
    mul_s1      = 32'd0;
    mul_s2      = 32'd0;
    rsp_valid   = 2'b00;
    rsp_data    = 32'd0;
    rsp_tag     = '0;
    busy        = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        req_ready = grant_c;
        if (accept_c) state_d = kill[gidx_c] ? ST_DRAIN : ST_BUSY;
      end
      ST_BUSY: begin
        mul_enabled = 1'b1;
        mul_funct3  = op_q.funct3;
        mul_s1      = op_q.s1;
        mul_s2      = op_q.s2;
        if (!mul_wait)       state_d = kill_own_c ? ST_IDLE : ST_RESP;
        else if (kill_own_c) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Unit cannot be aborted: keep it fed until it finishes, then discard
        mul_enabled = 1'b1;
        mul_funct3  = op_q.funct3;
        mul_s1      = op_q.s1;
        mul_s2      = op_q.s2;
        if (!mul_wait) state_d = ST_IDLE;
      end
      ST_RESP: begin
        rsp_valid = owner_q ? 2'b10 : 2'b01;
        rsp_data  = result_q;
        rsp_tag   = tag_q;
        if (kill_own_c || rsp_ready[owner_q]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand/tag latch on accept, result capture on unkilled completion
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_q     <= '0;
      tag_q    <= '0;
      owner_q  <= 1'b0;
      result_q <= '0;
    end else begin
      if (accept_c) begin
        op_q.funct3 <= gidx_c ? req_funct3[5:3] : req_funct3[2:0];
        op_q.s1     <= gidx_c ? req_s1[63:32]   : req_s1[31:0];
        op_q.s2     <= gidx_c ? req_s2[63:32]   : req_s2[31:0];
        tag_q       <= gidx_c ? req_tag[2*TAG_W-1:TAG_W] : req_tag[TAG_W-1:0];
        owner_q     <= gidx_c;
      end
      if ((state_q == ST_BUSY) && !mul_wait && !kill_own_c) result_q <= mul_rd;
    end
  end

endmodule

// File: tb/tb_mul_div_scheduler.sv
// Directed bench for mul_div_scheduler with a behavioural fixed-latency mul/div unit.
module tb_mul_div_scheduler;
  import riscv_muldiv_pkg::*;

  localparam int unsigned TAG_W = 4;

  logic               clock = 1'b0;
  logic               reset_n;
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [5:0]         req_funct3;
  logic [63:0]        req_s1;
  logic [63:0]        req_s2;
  logic [2*TAG_W-1:0] req_tag;
  logic [1:0]         kill;
  logic [1:0]         rsp_valid;
  logic [1:0]         rsp_ready;
  logic [31:0]        rsp_data;
  logic [TAG_W-1:0]   rsp_tag;
  logic               mul_enabled;
  logic [2:0]         mul_funct3;
  logic [31:0]        mul_s1;
  logic [31:0]        mul_s2;
  logic [31:0]        mul_rd;
  logic               mul_wait;
  logic               busy;

  int n_chk  = 0;
  int n_fail = 0;

  int unsigned unit_lat = 1;
  int unsigned ucnt;

  mul_div_scheduler #(.TAG_W(TAG_W)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_funct3  (req_funct3),
    .req_s1      (req_s1),
    .req_s2      (req_s2),
    .req_tag     (req_tag),
    .kill        (kill),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_tag     (rsp_tag),
    .mul_enabled (mul_enabled),
    .mul_funct3  (mul_funct3),
    .mul_s1      (mul_s1),
    .mul_s2      (mul_s2),
    .mul_rd      (mul_rd),
    .mul_wait    (mul_wait),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  // Behavioural unit: completes on the unit_lat-th enabled cycle, shares reset
  function automatic logic [31:0] unit_fn(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    case (f)
      F3_MUL:  return a * b;
      F3_DIV:  return (b == 32'd0) ? 32'hFFFF_FFFF : 32'($signed(a) / $signed(b));
      F3_DIVU: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      F3_REMU: return (b == 32'd0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n)         ucnt <= 0;
    else if (mul_enabled) ucnt <= ucnt + 1;
    else                  ucnt <= 0;
  end

  assign mul_wait = mul_enabled && ((ucnt + 1) < unit_lat);
  assign mul_rd   = (mul_enabled && !mul_wait) ? unit_fn(mul_funct3, mul_s1, mul_s2)
                                               : 32'hDEAD_BEEF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] oh(input int unsigned i);
    return (i == 0) ? 2'b01 : 2'b10;
  endfunction

  task automatic set_req(input int unsigned idx, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [TAG_W-1:0] t);
    if (idx == 0) begin
      req_funct3[2:0] = f3; req_s1[31:0] = a; req_s2[31:0] = b;
      req_tag[TAG_W-1:0] = t; req_valid[0] = 1'b1;
    end else begin
      req_funct3[5:3] = f3; req_s1[63:32] = a; req_s2[63:32] = b;
      req_tag[2*TAG_W-1:TAG_W] = t; req_valid[1] = 1'b1;
    end
  endtask

  typedef struct {
    int unsigned      idx;
    logic [2:0]       f3;
    logic [31:0]      s1;
    logic [31:0]      s2;
    logic [TAG_W-1:0] tag;
    int unsigned      lat;
    logic [31:0]      exp_data;
  } vec_t;

  vec_t vecs[5];

  // Single-requester op: accept, check unit drive, latency, response, release
  task automatic run_vec(input vec_t v);
    int n;
    unit_lat = v.lat;
    set_req(v.idx, v.f3, v.s1, v.s2, v.tag);
    #1;
    chk("vec_ready", 32'(req_ready), 32'(oh(v.idx)));
    @(posedge clock); #1;
    req_valid = 2'b00;
    @(negedge clock);
    chk("vec_mul_en", 32'(mul_enabled), 32'd1);
    chk("vec_mul_f3", 32'(mul_funct3), 32'(v.f3));
    chk("vec_mul_s1", mul_s1, v.s1);
    chk("vec_mul_s2", mul_s2, v.s2);
    chk("vec_busy_ready", 32'(req_ready), 32'd0);
    n = 1;
    while (rsp_valid == 2'b00 && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("vec_latency", 32'(n), 32'(v.lat + 1));
    chk("vec_rsp_valid", 32'(rsp_valid), 32'(oh(v.idx)));
    chk("vec_rsp_data", rsp_data, v.exp_data);
    chk("vec_rsp_tag", 32'(rsp_tag), 32'(v.tag));
    chk("vec_resp_mul_en", 32'(mul_enabled), 32'd0);
    rsp_ready = oh(v.idx);
    @(negedge clock);
    rsp_ready = 2'b00;
    chk("vec_idle_busy", 32'(busy), 32'd0);
    chk("vec_idle_rsp", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int en_cnt;
    int bad;
    int rsp_seen;
    logic [1:0] exp_g;

    vecs[0] = '{0, F3_MUL,  32'd7,          32'd6,   4'd3,  4, 32'd42};
    vecs[1] = '{1, F3_DIV,  32'd100,        32'd0,   4'd5,  1, 32'hFFFF_FFFF};
    vecs[2] = '{1, F3_REMU, 32'd17,         32'd5,   4'd9,  3, 32'd2};
    vecs[3] = '{0, F3_DIVU, 32'd100,        32'd7,   4'hF,  2, 32'd14};
    vecs[4] = '{1, F3_MUL,  32'hFFFF_FFFF,  32'd2,   4'd1,  1, 32'hFFFF_FFFE};

    // Reset with both requests pending: everything must read zero
    reset_n = 1'b0; kill = 2'b00; rsp_ready = 2'b00;
    req_valid = 2'b00; req_funct3 = '0; req_s1 = '0; req_s2 = '0; req_tag = '0;
    set_req(0, F3_MUL, 32'd1, 32'd1, 4'd1);
    set_req(1, F3_MUL, 32'd2, 32'd2, 4'd2);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_mul_en", 32'(mul_enabled), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    req_valid = 2'b00;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Both requesters valid continuously: grants alternate 0,1,0,1
    unit_lat = 2;
    set_req(0, F3_MUL, 32'd3, 32'd4, 4'd2);
    set_req(1, F3_MUL, 32'd5, 32'd5, 4'd7);
    rsp_ready = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      n = 0;
      while (req_ready == 2'b00 && n < 20) begin
        @(negedge clock);
        n++;
      end
      chk("rr_grant", 32'(req_ready), 32'(exp_g));
      n = 0;
      do begin
        @(negedge clock);
        n++;
      end while (rsp_valid == 2'b00 && n < 20);
      chk("rr_rsp_owner", 32'(rsp_valid), 32'(exp_g));
      chk("rr_rsp_tag", 32'(rsp_tag), (exp_g == 2'b01) ? 32'd2 : 32'd7);
      chk("rr_rsp_data", rsp_data, (exp_g == 2'b01) ? 32'd12 : 32'd25);
    end
    req_valid = 2'b00;
    @(negedge clock);
    rsp_ready = 2'b00;

    // Kill req0 in its 2nd BUSY cycle of a 33-cycle DIV; req1 waits
    unit_lat = 33;
    set_req(0, F3_DIV, 32'd1000, 32'd10, 4'd4);
    set_req(1, F3_DIVU, 32'd50, 32'd5, 4'd6);
    #1;
    chk("kill_first_grant", 32'(req_ready), 32'b01);
    @(posedge clock); #1;
    req_valid[0] = 1'b0;
    n = 0; en_cnt = 0; rsp_seen = 0; bad = 0;
    while (n < 60) begin
      @(negedge clock);
      n++;
      kill = (n == 2) ? 2'b01 : 2'b00;
      if (rsp_valid != 2'b00) rsp_seen++;
      if (!mul_enabled) break;
      en_cnt++;
      if (mul_s1 !== 32'd1000 || mul_s2 !== 32'd10 || mul_funct3 !== F3_DIV || req_ready !== 2'b00)
        bad++;
    end
    kill = 2'b00;
    chk("kill_en_cycles", 32'(en_cnt), 32'd33);
    chk("kill_drain_hold", 32'(bad), 32'd0);
    chk("kill_no_rsp", 32'(rsp_seen), 32'd0);
    chk("kill_exit_cycle", 32'(n), 32'd34);
    chk("kill_next_grant", 32'(req_ready), 32'b10);

    // req1 runs right after; a kill of the non-owner is ignored
    unit_lat = 1;
    @(posedge clock); #1;
    req_valid = 2'b00;
    @(negedge clock);
    kill = 2'b01;
    @(negedge clock);
    kill = 2'b00;
    chk("nonowner_rsp_valid", 32'(rsp_valid), 32'b10);
    chk("nonowner_rsp_data", rsp_data, 32'd10);
    chk("nonowner_rsp_tag", 32'(rsp_tag), 32'd6);
    rsp_ready = 2'b10;
    @(negedge clock);
    rsp_ready = 2'b00;
    chk("nonowner_idle", 32'(busy), 32'd0);

    // Kill on the completion cycle: no response, straight to IDLE
    unit_lat = 1;
    set_req(0, F3_MUL, 32'd9, 32'd9, 4'd1);
    @(posedge clock); #1;
    req_valid = 2'b00;
    @(negedge clock);
    kill = 2'b01;
    @(negedge clock);
    kill = 2'b00;
    chk("killdone_rsp", 32'(rsp_valid), 32'd0);
    chk("killdone_busy", 32'(busy), 32'd0);

    // Kill in the accept cycle: unit still runs its 3 cycles, then dropped
    unit_lat = 3;
    set_req(1, F3_MUL, 32'd2, 32'd2, 4'd3);
    kill = 2'b10;
    @(posedge clock); #1;
    req_valid = 2'b00;
    kill = 2'b00;
    n = 0; en_cnt = 0; rsp_seen = 0;
    while (n < 20) begin
      @(negedge clock);
      n++;
      if (rsp_valid != 2'b00) rsp_seen++;
      if (!mul_enabled) break;
      en_cnt++;
    end
    chk("killacc_en_cycles", 32'(en_cnt), 32'd3);
    chk("killacc_no_rsp", 32'(rsp_seen), 32'd0);

    // RESP stalled 5 cycles, then kill and rsp_ready together drop it
    unit_lat = 2;
    set_req(0, F3_MUL, 32'd11, 32'd13, 4'hA);
    @(posedge clock); #1;
    req_valid = 2'b00;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (rsp_valid == 2'b00 && n < 20);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid !== 2'b01 || rsp_data !== 32'd143 || rsp_tag !== 4'hA) bad++;
      kill = (i == 2) ? 2'b10 : 2'b00;
      @(negedge clock);
    end
    kill = 2'b00;
    chk("stall_hold", 32'(bad), 32'd0);
    chk("stall_still_valid", 32'(rsp_valid), 32'b01);
    kill = 2'b01; rsp_ready = 2'b01;
    @(negedge clock);
    kill = 2'b00; rsp_ready = 2'b00;
    chk("stallkill_rsp", 32'(rsp_valid), 32'd0);
    chk("stallkill_busy", 32'(busy), 32'd0);

    // Reset pulsed mid-BUSY of a req0 op; pointer must return to favour req0
    unit_lat = 10;
    set_req(0, F3_MUL, 32'd3, 32'd3, 4'd2);
    @(posedge clock); #1;
    req_valid = 2'b00;
    repeat (3) @(negedge clock);
    chk("prereset_busy", 32'(busy), 32'd1);
    set_req(0, F3_MUL, 32'd4, 32'd5, 4'd9);
    set_req(1, F3_MUL, 32'd6, 32'd6, 4'd8);
    reset_n = 1'b0;
    #1;
    chk("midrst_req_ready", 32'(req_ready), 32'd0);
    chk("midrst_mul_en", 32'(mul_enabled), 32'd0);
    chk("midrst_mul_s1", mul_s1, 32'd0);
    chk("midrst_mul_s2", mul_s2, 32'd0);
    chk("midrst_mul_f3", 32'(mul_funct3), 32'd0);
    chk("midrst_rsp", 32'(rsp_valid), 32'd0);
    chk("midrst_rsp_data", rsp_data, 32'd0);
    chk("midrst_rsp_tag", 32'(rsp_tag), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk("postrst_grant", 32'(req_ready), 32'b01);
    @(posedge clock); #1;
    req_valid = 2'b00;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (rsp_valid == 2'b00 && n < 40);
    chk("postrst_latency", 32'(n), 32'd11);
    chk("postrst_rsp_valid", 32'(rsp_valid), 32'b01);
    chk("postrst_rsp_data", rsp_data, 32'd20);
    chk("postrst_rsp_tag", 32'(rsp_tag), 32'd9);
    rsp_ready = 2'b01;
    @(negedge clock);
    rsp_ready = 2'b00;
    chk("postrst_idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
